// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter
// Shares a single DDR Wishbone slave port between the instruction cache
// refill master (m0, read-only) and the data cache master (m1, read/write).
// Simultaneous requests are resolved round-robin. A granted transaction
// that sees no s_ack within TIMEOUT bus cycles is aborted with an error pulse.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   m0_addr/cyc/stb          ICache request (64-byte aligned line address)
//   m0_din, m0_ack, m0_err   ICache read line, completion and timeout pulses
//   m1_addr/dout/we/cyc/stb  DCache request and write-back line
//   m1_din, m1_ack, m1_err   DCache read line, completion and timeout pulses
//   s_addr/dout/we/cyc/stb   forwarded request to the DDR slave
//   s_din, s_ack             DDR slave read data and acknowledge
//
// Parameter
//   TIMEOUT  bus cycles a granted transaction may wait for s_ack (0 = never)

module cache_bus_arbiter #(
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  m0_addr,
  input  logic         m0_cyc,
  input  logic         m0_stb,
  output logic [511:0] m0_din,
  output logic         m0_ack,
  output logic         m0_err,
  input  logic [31:0]  m1_addr,
  input  logic [511:0] m1_dout,
  input  logic         m1_we,
  input  logic         m1_cyc,
  input  logic         m1_stb,
  output logic [511:0] m1_din,
  output logic         m1_ack,
  output logic         m1_err,
  output logic [31:0]  s_addr,
  output logic [511:0] s_dout,
  output logic         s_we,
  output logic         s_cyc,
  output logic         s_stb,
  input  logic [511:0] s_din,
  input  logic         s_ack
);

  // Counter is wide enough to hold TIMEOUT itself so it can saturate there.
  localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(LAST_I);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS0    = 2'd1,
    BUS1    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          last_grant;
  logic [CW-1:0] cnt;
  logic          req0;
  logic          req1;
  logic          timeout_hit;

  assign req0        = m0_cyc & m0_stb;
  assign req1        = m1_cyc & m1_stb;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // State register, round-robin history and wait counter. last_grant resets
  // to 1 so that m0 wins the first tie. The counter is cleared whenever no
  // master owns the bus, which leaves it at zero on entry to BUS0/BUS1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == BUS0) begin
        last_grant <= 1'b0;
      end else if (state == IDLE && state_next == BUS1) begin
        last_grant <= 1'b1;
      end
      if (state == BUS0 || state == BUS1) begin
        if (!s_ack && (TIMEOUT != 0) && (cnt != CNT_MAX)) begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // Next-state and error pulses. Within a grant, s_ack has priority over a
  // master abort, and an abort has priority over the timeout, so an abandoned
  // cycle never reports an error.
  always_comb begin
    state_next = state;
    m0_err     = 1'b0;
    m1_err     = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_next = last_grant ? BUS0 : BUS1;
        end else if (req0) begin
          state_next = BUS0;
        end else if (req1) begin
          state_next = BUS1;
        end
      end
      BUS0: begin
        if (s_ack) begin
          state_next = RELEASE;
        end else if (!m0_cyc) begin
          state_next = IDLE;
        end else if (timeout_hit) begin
          state_next = RELEASE;
          m0_err     = 1'b1;
        end
      end
      BUS1: begin
        if (s_ack) begin
          state_next = RELEASE;
        end else if (!m1_cyc) begin
          state_next = IDLE;
        end else if (timeout_hit) begin
          state_next = RELEASE;
          m1_err     = 1'b1;
        end
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Slave-side mux, driven purely from the state so that an asynchronous
  // reset removes the request from the slave without waiting for a clock.
  always_comb begin
    s_addr = '0;
    s_dout = '0;
    s_we   = 1'b0;
    s_cyc  = 1'b0;
    case (state)
      BUS0: begin
        s_addr = m0_addr;
        s_cyc  = req0;
      end
      BUS1: begin
        s_addr = m1_addr;
        s_dout = m1_dout;
        s_we   = m1_we;
        s_cyc  = req1;
      end
      default: ;
    endcase
  end

  assign s_stb  = s_cyc;
  assign m0_din = s_din;
  assign m1_din = s_din;
  assign m0_ack = s_ack && (state == BUS0);
  assign m1_ack = s_ack && (state == BUS1);

endmodule
